// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle: hazard/redirect/memory/halt requests in, per-stage enables out.
interface pipe_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             iw_hazard;
  logic             iw_br_taken;
  logic             iw_mem_busy;
  logic             iw_halt;
  logic             iw_resume;
  logic             or_pc_en;
  logic             or_ifid_en;
  logic             or_ifid_flush;
  logic             or_idex_en;
  logic             or_idex_bubble;
  logic             or_exma_en;
  logic             or_mawb_en;
  logic [1:0]       or_state;
  logic [CNT_W-1:0] or_stall_cnt;
  logic [CNT_W-1:0] or_flush_cnt;

  modport master (
    output iw_hazard, iw_br_taken, iw_mem_busy, iw_halt, iw_resume,
    input  or_pc_en, or_ifid_en, or_ifid_flush, or_idex_en, or_idex_bubble,
           or_exma_en, or_mawb_en, or_state, or_stall_cnt, or_flush_cnt
  );

  modport slave (
    input  iw_hazard, iw_br_taken, iw_mem_busy, iw_halt, iw_resume,
    output or_pc_en, or_ifid_en, or_ifid_flush, or_idex_en, or_idex_bubble,
           or_exma_en, or_mawb_en, or_state, or_stall_cnt, or_flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// 5-stage pipeline sequencer: post-reset clearing, stall/redirect/mem-wait/halt decode.
// Optional stall/flush performance counters enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int INIT_CYC = 4,
  parameter int CNT_W    = 16
) (
  input logic        iw_clk,
  input logic        iw_rst_n,
  pipe_ctrl_if.slave bus
);
  // state   | meaning
  // S_INIT  | post-reset flush of every stage for INIT_CYC cycles
  // S_RUN   | normal issue, hazard/branch decode
  // S_MWAIT | data memory busy, whole pipe frozen
  // S_HALT  | front end held, back end drains
  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_MWAIT = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam int INIT_W = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYC - 1);

  state_t            r_state;
  logic [INIT_W-1:0] r_init_cnt;

  logic w_run_or_wait, w_active, w_busy_wait;
  logic w_pc_en, w_ifid_en, w_ifid_flush, w_idex_en, w_idex_bubble, w_exma_en, w_mawb_en;

  assign w_run_or_wait = (r_state == S_RUN) || (r_state == S_MWAIT);
  assign w_active      = w_run_or_wait && !bus.iw_mem_busy;
  assign w_busy_wait   = w_run_or_wait && bus.iw_mem_busy;

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      r_state    <= S_INIT;
      r_init_cnt <= '0;
    end else begin
      case (r_state)
        S_INIT: begin
          if (r_init_cnt == INIT_LAST) r_state <= S_RUN;
          else                         r_init_cnt <= r_init_cnt + 1'b1;
        end
        S_RUN, S_MWAIT: begin
          if (bus.iw_mem_busy)  r_state <= S_MWAIT;
          else if (bus.iw_halt) r_state <= S_HALT;
          else                  r_state <= S_RUN;
        end
        S_HALT: begin
          if (bus.iw_resume && !bus.iw_mem_busy) r_state <= S_RUN;
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  // Combinational so a load-use stall takes effect in the cycle it is raised.
  always_comb begin
    w_pc_en       = 1'b0;
    w_ifid_en     = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_en     = 1'b0;
    w_idex_bubble = 1'b0;
    w_exma_en     = 1'b0;
    w_mawb_en     = 1'b0;
    case (r_state)
      S_INIT: begin
        w_ifid_en     = 1'b1;
        w_ifid_flush  = 1'b1;
        w_idex_en     = 1'b1;
        w_idex_bubble = 1'b1;
        w_exma_en     = 1'b1;
        w_mawb_en     = 1'b1;
      end
      S_RUN, S_MWAIT: begin
        if (w_active) begin
          w_idex_en = 1'b1;
          w_exma_en = 1'b1;
          w_mawb_en = 1'b1;
          if (bus.iw_br_taken) begin
            // Redirect wins over hazard: the stalled instruction is squashed anyway.
            w_pc_en       = 1'b1;
            w_ifid_en     = 1'b1;
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
          end else if (bus.iw_hazard) begin
            w_idex_bubble = 1'b1;
          end else begin
            w_pc_en   = 1'b1;
            w_ifid_en = 1'b1;
          end
        end
      end
      S_HALT: begin
        if (!bus.iw_mem_busy) begin
          w_idex_en     = 1'b1;
          w_idex_bubble = 1'b1;
          w_exma_en     = 1'b1;
          w_mawb_en     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.or_pc_en       = w_pc_en;
  assign bus.or_ifid_en     = w_ifid_en;
  assign bus.or_ifid_flush  = w_ifid_flush;
  assign bus.or_idex_en     = w_idex_en;
  assign bus.or_idex_bubble = w_idex_bubble;
  assign bus.or_exma_en     = w_exma_en;
  assign bus.or_mawb_en     = w_mawb_en;
  assign bus.or_state       = r_state;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic w_stall_inc, w_flush_inc;

  assign w_stall_inc = (w_active && bus.iw_hazard && !bus.iw_br_taken) || w_busy_wait;
  assign w_flush_inc = w_active && bus.iw_br_taken;

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_inc && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign bus.or_stall_cnt = r_stall_cnt;
  assign bus.or_flush_cnt = r_flush_cnt;
`else
  logic w_unused_busy;
  assign w_unused_busy    = w_busy_wait;
  assign bus.or_stall_cnt = '0;
  assign bus.or_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios then randomized traffic with resets.
module tb_pipe_ctrl;
  localparam int INIT_CYC = 4;
  localparam int CNT_W    = 6;
  localparam int SAT      = (1 << CNT_W) - 1;

  typedef logic [2*CNT_W+8:0] exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();
  pipe_ctrl #(.INIT_CYC(INIT_CYC), .CNT_W(CNT_W)) dut (
    .iw_clk  (clk),
    .iw_rst_n(rst_n),
    .bus     (bus)
  );

  exp_t q[$];
  int n_pass  = 0;
  int n_total = 0;

  // Reference: state as an integer 0..3, counters as plain integers.
  int m_st, m_init, m_stall, m_flush;

  task automatic m_reset();
    m_st = 0; m_init = 0; m_stall = 0; m_flush = 0;
  endtask

  // Called at posedge+1: drive, push expectation for this cycle, advance model at next edge.
  task automatic cyc(input bit h, input bit br, input bit busy, input bit halt, input bit res);
    logic [6:0] en;
    int  nst;
    bit  act, s_inc, f_inc;
    logic [CNT_W-1:0] ev_s, ev_f;
    bus.iw_hazard = h; bus.iw_br_taken = br; bus.iw_mem_busy = busy;
    bus.iw_halt = halt; bus.iw_resume = res;
    act = (m_st == 1 || m_st == 2) && !busy;
    en  = 7'b0;
    nst = m_st;
    // en order: pc, ifid, ifid_flush, idex, idex_bubble, exma, mawb
    case (m_st)
      0: begin en = 7'b0111111; nst = (m_init == INIT_CYC - 1) ? 1 : 0; end
      1, 2: begin
        if (busy) begin en = 7'b0; nst = 2; end
        else begin
          if (br)     en = 7'b1111111;
          else if (h) en = 7'b0001111;
          else        en = 7'b1101011;
          nst = halt ? 3 : 1;
        end
      end
      default: begin
        if (!busy) en = 7'b0001111;
        nst = (res && !busy) ? 1 : 3;
      end
    endcase
    s_inc = (act && h && !br) || (busy && (m_st == 1 || m_st == 2));
    f_inc = act && br;
`ifdef PIPE_CTRL_PERF_EN
    ev_s = CNT_W'(m_stall);
    ev_f = CNT_W'(m_flush);
`else
    ev_s = '0;
    ev_f = '0;
`endif
    q.push_back({en, 2'(m_st), ev_s, ev_f});
    @(posedge clk); #1;
    if (m_st == 0 && nst == 0) m_init++;
    m_st = nst;
    if (s_inc && m_stall < SAT) m_stall++;
    if (f_inc && m_flush < SAT) m_flush++;
  endtask

  // Async reset asserted between edges: INIT must be visible before the next clock.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    n_total++;
    if (bus.or_state === 2'd0 && bus.or_pc_en === 1'b0 && bus.or_ifid_flush === 1'b1 &&
        bus.or_stall_cnt === '0 && bus.or_flush_cnt === '0)
      n_pass++;
    else
      $display("FAIL async_reset t=%0t actual state=%0d pc_en=%b flush=%b stall=%0d fcnt=%0d required state=0 pc_en=0 flush=1 counts=0",
               $time, bus.or_state, bus.or_pc_en, bus.or_ifid_flush, bus.or_stall_cnt, bus.or_flush_cnt);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_reset();
  endtask

  initial begin : monitor
    forever begin
      exp_t e, a;
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        a = {bus.or_pc_en, bus.or_ifid_en, bus.or_ifid_flush, bus.or_idex_en,
             bus.or_idex_bubble, bus.or_exma_en, bus.or_mawb_en, bus.or_state,
             bus.or_stall_cnt, bus.or_flush_cnt};
        n_total++;
        if (a === e) n_pass++;
        else $display("FAIL ctrl_vec t=%0t actual=%h required=%h", $time, a, e);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "timeout");
  end

  initial begin : stim
    bus.iw_hazard = 0; bus.iw_br_taken = 0; bus.iw_mem_busy = 0;
    bus.iw_halt = 0; bus.iw_resume = 0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    // reset release: INIT_CYC cycles of INIT, then RUN
    repeat (6) cyc(0, 0, 0, 0, 0);
    // load-use stall for one cycle
    cyc(1, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
    // branch overrides hazard
    cyc(1, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0);
    // memory wait with pending hazard, then busy drop
    repeat (3) cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
    // halt, ignored halt while halted, resume
    cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 1, 0); cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 0);
    // stall counter saturation
    repeat (SAT + 8) cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    // reset while in MWAIT
    cyc(0, 0, 1, 0, 0); cyc(0, 0, 1, 0, 0);
    do_reset();
    repeat (INIT_CYC + 1) cyc(0, 0, 0, 0, 0);
    // randomized traffic with occasional resets
    repeat (500) begin
      if ($urandom_range(0, 79) == 0 && m_st != 0) do_reset();
      else cyc($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 2) == 0);
    end
    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL drain actual=%0d required=0 pending", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
